// File: rtl/contador_distancia.sv
//==============================================================================
// Module     : contador_distancia
// Description: Measures the high time of a synchronised ultrasonic echo pulse
//              in clock cycles and converts it to a D-digit BCD distance.
//              The resolution (cm or mm) is latched at pulse start. The result
//              is rounded to the nearest unit, with halves rounded up. It
//              saturates at all-9s and raises a flag when it does. A pulse that
//              stays high for MAX_TICKS cycles is aborted as a timeout.
// Ports      : clock    - system clock
//              reset    - asynchronous active-high reset
//              pulso    - echo pulse (synchronous to clock)
//              modo     - 0 = cm, 1 = mm (sampled at pulse start)
//              digitos  - registered BCD result, digit 0 in [3:0]
//              pronto   - one-cycle strobe, new result on digitos
//              overflow - last result saturated at all-9s
//              timeout  - last measurement aborted at MAX_TICKS
//              ocupado  - measurement in progress
// Revision   : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module contador_distancia #(
  parameter int R_CM      = 2941,
  parameter int R_MM      = 294,
  parameter int N         = 12,
  parameter int D         = 3,
  parameter int MAX_TICKS = 1_500_000,
  parameter int NT        = 21
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           pulso,
  input  logic           modo,
  output logic [4*D-1:0] digitos,
  output logic           pronto,
  output logic           overflow,
  output logic           timeout,
  output logic           ocupado
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CONTA  = 3'd1,
    S_ARRED  = 3'd2,
    S_FIM    = 3'd3,
    S_ESPERA = 3'd4
  } state_t;

  // Ratios are held one bit wider than the tick counter so that R = 2**N
  // still compares correctly against tick+1.
  localparam logic [N:0]    C_R_CM    = (N+1)'(R_CM);
  localparam logic [N:0]    C_R_MM    = (N+1)'(R_MM);
  localparam logic [N:0]    C_HALF_CM = (N+1)'((R_CM + 1) / 2);
  localparam logic [N:0]    C_HALF_MM = (N+1)'((R_MM + 1) / 2);
  localparam logic [NT-1:0] C_MAX     = NT'(MAX_TICKS);

  state_t         state_q, state_d;
  logic           modo_q, modo_d;
  logic [N-1:0]   tick_q, tick_d;
  logic [NT-1:0]  total_q, total_d;
  logic [4*D-1:0] acc_q, acc_d;
  logic           sat_q, sat_d;
  logic [4*D-1:0] digitos_q, digitos_d;
  logic           pronto_q, pronto_d;
  logic           overflow_q, overflow_d;
  logic           timeout_q, timeout_d;

  logic [4*D-1:0] w_all9;
  logic [4*D-1:0] w_acc_inc;
  logic           w_acc_full;
  logic           w_carry;
  logic [N:0]     w_r;
  logic [N:0]     w_half;
  logic [N:0]     w_tick_nxt;

  genvar gi;
  generate
    for (gi = 0; gi < D; gi++) begin : g_nines
      assign w_all9[4*gi +: 4] = 4'd9;
    end
  endgenerate

  assign w_r        = modo_q ? C_R_MM : C_R_CM;
  assign w_half     = modo_q ? C_HALF_MM : C_HALF_CM;
  assign w_tick_nxt = {1'b0, tick_q} + (N+1)'(1);

  // Decimal increment with per-digit ripple carry; w_acc_full flags all-9s,
  // in which case the caller holds the accumulator instead of wrapping.
  always_comb begin
    w_acc_inc  = acc_q;
    w_acc_full = 1'b1;
    w_carry    = 1'b1;
    for (int i = 0; i < D; i++) begin
      if (acc_q[4*i +: 4] != 4'd9) begin
        w_acc_full = 1'b0;
      end
      if (w_carry) begin
        if (acc_q[4*i +: 4] == 4'd9) begin
          w_acc_inc[4*i +: 4] = 4'd0;
        end else begin
          w_acc_inc[4*i +: 4] = acc_q[4*i +: 4] + 4'd1;
          w_carry             = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    modo_d     = modo_q;
    tick_d     = tick_q;
    total_d    = total_q;
    acc_d      = acc_q;
    sat_d      = sat_q;
    digitos_d  = digitos_q;
    pronto_d   = 1'b0;
    overflow_d = overflow_q;
    timeout_d  = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (pulso) begin
          state_d = S_CONTA;
          modo_d  = modo;
          tick_d  = N'(1);
          total_d = NT'(1);
          acc_d   = '0;
          sat_d   = 1'b0;
        end
      end

      S_CONTA: begin
        if (pulso) begin
          total_d = total_q + NT'(1);
          if (w_tick_nxt == w_r) begin
            tick_d = '0;
            if (w_acc_full) begin
              sat_d = 1'b1;
            end else begin
              acc_d = w_acc_inc;
            end
          end else begin
            tick_d = w_tick_nxt[N-1:0];
          end
          // Timeout publishes its saturated result on the same edge it is detected.
          if (total_q + NT'(1) == C_MAX) begin
            state_d    = S_ESPERA;
            digitos_d  = w_all9;
            overflow_d = 1'b1;
            timeout_d  = 1'b1;
            pronto_d   = 1'b1;
          end
        end else begin
          state_d = S_ARRED;
        end
      end

      S_ARRED: begin
        // The leftover ticks are at least half a unit, so round up.
        if ({1'b0, tick_q} >= w_half) begin
          if (w_acc_full) begin
            sat_d = 1'b1;
          end else begin
            acc_d = w_acc_inc;
          end
        end
        state_d = S_FIM;
      end

      S_FIM: begin
        digitos_d  = acc_q;
        overflow_d = sat_q;
        timeout_d  = 1'b0;
        pronto_d   = 1'b1;
        state_d    = S_IDLE;
      end

      S_ESPERA: begin
        if (!pulso) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      modo_q     <= 1'b0;
      tick_q     <= '0;
      total_q    <= '0;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      digitos_q  <= '0;
      pronto_q   <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      modo_q     <= modo_d;
      tick_q     <= tick_d;
      total_q    <= total_d;
      acc_q      <= acc_d;
      sat_q      <= sat_d;
      digitos_q  <= digitos_d;
      pronto_q   <= pronto_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  assign digitos  = digitos_q;
  assign pronto   = pronto_q;
  assign overflow = overflow_q;
  assign timeout  = timeout_q;
  assign ocupado  = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_contador_distancia.sv
//==============================================================================
// Module     : tb_contador_distancia
// Description: Directed self-checking bench for contador_distancia with
//              R_CM=10, R_MM=4, D=2, MAX_TICKS=1200.
// Revision   : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_contador_distancia;

  logic       clock;
  logic       reset;
  logic       pulso;
  logic       modo;
  logic [7:0] digitos;
  logic       pronto;
  logic       overflow;
  logic       timeout;
  logic       ocupado;

  int n_tests = 0;
  int n_fail  = 0;

  contador_distancia #(
    .R_CM      (10),
    .R_MM      (4),
    .N         (4),
    .D         (2),
    .MAX_TICKS (1200),
    .NT        (11)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .pulso    (pulso),
    .modo     (modo),
    .digitos  (digitos),
    .pronto   (pronto),
    .overflow (overflow),
    .timeout  (timeout),
    .ocupado  (ocupado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Holds pulso high for h rising edges, optionally flipping modo after
  // tog_at edges (0 = never). Returns at the negedge where pulso drops.
  task automatic drive_pulse(input int h, input logic m, input int tog_at);
    modo  = m;
    pulso = 1'b1;
    for (int k = 0; k < h; k++) begin
      @(negedge clock);
      if (k + 1 == tog_at) modo = ~modo;
    end
    pulso = 1'b0;
  endtask

  // Expects pronto on the third negedge after pulso drops (two clocks after
  // the first low sample), then checks the published result.
  task automatic wait_result(input string tag, input logic [7:0] exp_dig,
                             input logic exp_ovf, input logic exp_to,
                             input logic chk_strobe);
    int lat;
    bit seen;
    lat  = 0;
    seen = 0;
    while (lat < 10 && !seen) begin
      @(negedge clock);
      lat++;
      if (pronto) seen = 1;
    end
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_dig"}, digitos, exp_dig);
    chk({tag, "_ovf"}, overflow, exp_ovf);
    chk({tag, "_to"},  timeout, exp_to);
    if (chk_strobe) begin
      @(negedge clock);
      chk({tag, "_strobe"}, pronto, 0);
      chk({tag, "_idle"}, ocupado, 0);
    end
  endtask

  task automatic measure(input string tag, input int h, input logic m, input int tog_at,
                         input logic [7:0] exp_dig, input logic exp_ovf);
    drive_pulse(h, m, tog_at);
    chk({tag, "_busy"}, ocupado, 1);
    wait_result(tag, exp_dig, exp_ovf, 1'b0, 1'b1);
  endtask

  initial begin
    int first_at;
    int cnt;

    reset = 1'b1;
    pulso = 1'b0;
    modo  = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_dig", digitos, 8'h00);
    chk("rst_pronto", pronto, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_to", timeout, 0);
    chk("rst_busy", ocupado, 0);
    reset = 1'b0;
    @(negedge clock);

    // cm basic and rounding boundaries
    measure("cm24", 24, 1'b0, 0, 8'h02, 1'b0);
    measure("cm25", 25, 1'b0, 0, 8'h03, 1'b0);
    measure("cm5",  5,  1'b0, 0, 8'h01, 1'b0);
    measure("cm4",  4,  1'b0, 0, 8'h00, 1'b0);
    measure("cm1",  1,  1'b0, 0, 8'h00, 1'b0);

    // mm mode, mid-pulse modo change ignored
    measure("mm26",  26, 1'b1, 0,  8'h07, 1'b0);
    measure("mmtog", 26, 1'b1, 10, 8'h07, 1'b0);
    measure("mm2",   2,  1'b1, 0,  8'h01, 1'b0);
    measure("mm1",   1,  1'b1, 0,  8'h00, 1'b0);
    measure("cmtog", 24, 1'b0, 10, 8'h02, 1'b0);

    // Saturation, then recovery
    measure("sat1000", 1000, 1'b0, 0, 8'h99, 1'b1);
    measure("cm30",    30,   1'b0, 0, 8'h03, 1'b0);

    // Back-to-back: new pulse starts in the IDLE cycle right after FIM
    drive_pulse(12, 1'b0, 0);
    wait_result("b2b_a", 8'h01, 1'b0, 1'b0, 1'b0);
    drive_pulse(17, 1'b0, 0);
    wait_result("b2b_b", 8'h02, 1'b0, 1'b0, 1'b1);

    // Timeout: pulso high for 1500 cycles
    first_at = 0;
    cnt      = 0;
    modo     = 1'b0;
    pulso    = 1'b1;
    for (int k = 1; k <= 1500; k++) begin
      @(negedge clock);
      if (pronto) begin
        cnt++;
        if (first_at == 0) first_at = k;
      end
    end
    chk("to_first", first_at, 1200);
    chk("to_count", cnt, 1);
    chk("to_dig", digitos, 8'h99);
    chk("to_ovf", overflow, 1);
    chk("to_flag", timeout, 1);
    chk("to_busy", ocupado, 1);
    pulso = 1'b0;
    @(negedge clock);
    chk("to_release", ocupado, 0);
    chk("to_nopronto", pronto, 0);

    // Async reset mid-measurement
    pulso = 1'b1;
    repeat (15) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("ar_dig", digitos, 8'h00);
    chk("ar_ovf", overflow, 0);
    chk("ar_to", timeout, 0);
    chk("ar_busy", ocupado, 0);
    chk("ar_pronto", pronto, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    pulso = 1'b0;
    cnt   = 0;
    repeat (6) begin
      @(negedge clock);
      if (pronto) cnt++;
    end
    chk("ar_nopronto", cnt, 0);
    measure("ar_cm20", 20, 1'b0, 0, 8'h02, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
